// File: rtl/uart_tx_pkg.sv
// Shared types and defaults for the FIFO-draining UART transmitter.
package uart_tx_pkg;

  // Transmitter sequencing states
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_POP    = 3'd1,
    ST_LOAD   = 3'd2,
    ST_START  = 3'd3,
    ST_DATA   = 3'd4,
    ST_PARITY = 3'd5,
    ST_STOP   = 3'd6
  } tx_state_t;

  localparam int DEF_WIDTH        = 8;
  localparam int DEF_CLKS_PER_BIT = 16;

  // Parity of a data word; odd=1 inverts the even-parity result.
  // Zero-extension of narrower words does not change the XOR reduction.
  function automatic logic parity_of(input logic [63:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 and strobes bit_end on the
// final cycle of every bit. bit_last announces that bit_end will be high in
// the following cycle so the caller can register outputs aligned to it.
module uart_baud_gen
#(
  parameter int CLKS_PER_BIT = 16
)
(
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic bit_end,
  output logic bit_last
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_r;
  logic [CW-1:0] cnt_next_s;
  logic          bit_end_r;

  // Next count: restart on clear or at the end of a bit period
  always_comb begin
    cnt_next_s = cnt_r;
    if (clear) begin
      cnt_next_s = {CW{1'b0}};
    end else if (cnt_r == LAST) begin
      cnt_next_s = {CW{1'b0}};
    end else begin
      cnt_next_s = cnt_r + CW'(1);
    end
  end

  assign bit_last = (cnt_next_s == LAST);
  assign bit_end  = bit_end_r;

  // Counter and registered end-of-bit strobe
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r     <= {CW{1'b0}};
      bit_end_r <= 1'b0;
    end else begin
      cnt_r     <= cnt_next_s;
      bit_end_r <= bit_last;
    end
  end

endmodule

// File: rtl/uart_tx_drain.sv
// Pops words from a registered-read FIFO and serialises them as UART frames:
// start bit, WIDTH data bits LSB first, optional parity, one stop bit.
// Every output is a flop loaded from the next-state decode, so outputs line
// up with the state they describe without any combinational input path.
module uart_tx_drain
  import uart_tx_pkg::*;
#(
  parameter int WIDTH        = DEF_WIDTH,
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0
)
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             fifo_empty,
  input  logic [WIDTH-1:0] fifo_data,
  output logic             fifo_rd_en,
  output logic             tx,
  output logic             busy,
  output logic             tx_done,
  output logic [15:0]      bytes_sent
);

  localparam int BW = $clog2(WIDTH + 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);
  localparam logic PAR_EN  = (PARITY_EN  != 0) ? 1'b1 : 1'b0;
  localparam logic PAR_ODD = (PARITY_ODD != 0) ? 1'b1 : 1'b0;

  tx_state_t        state_r,   state_next_s;
  logic [WIDTH-1:0] shift_r,   shift_next_s;
  logic [BW-1:0]    bit_cnt_r, bit_cnt_next_s;
  logic             parity_r,  parity_next_s;
  logic [15:0]      bytes_r,   bytes_next_s;
  logic             tx_r,      tx_s;
  logic             rd_en_r,   rd_en_s;
  logic             busy_r,    busy_s;
  logic             done_r,    done_s;
  logic             clear_s;
  logic             bit_end_s;
  logic             bit_last_s;

  // The bit period restarts on the cycle that enters START
  assign clear_s = (state_r == ST_LOAD);

  uart_baud_gen #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (clear_s),
    .bit_end  (bit_end_s),
    .bit_last (bit_last_s)
  );

  // Next-state, datapath and frame-count decode
  always_comb begin
    state_next_s   = state_r;
    shift_next_s   = shift_r;
    bit_cnt_next_s = bit_cnt_r;
    parity_next_s  = parity_r;
    bytes_next_s   = bytes_r;
    case (state_r)
      ST_IDLE: begin
        if (enable && !fifo_empty) state_next_s = ST_POP;
        else                       state_next_s = ST_IDLE;
      end
      ST_POP: begin
        state_next_s = ST_LOAD;
      end
      ST_LOAD: begin
        shift_next_s   = fifo_data;
        parity_next_s  = parity_of(64'(fifo_data), PAR_ODD);
        bit_cnt_next_s = {BW{1'b0}};
        state_next_s   = ST_START;
      end
      ST_START: begin
        if (bit_end_s) state_next_s = ST_DATA;
        else           state_next_s = ST_START;
      end
      ST_DATA: begin
        if (bit_end_s) begin
          shift_next_s = {1'b0, shift_r[WIDTH-1:1]};
          if (bit_cnt_r == LAST_BIT) begin
            bit_cnt_next_s = {BW{1'b0}};
            state_next_s   = PAR_EN ? ST_PARITY : ST_STOP;
          end else begin
            bit_cnt_next_s = bit_cnt_r + BW'(1);
            state_next_s   = ST_DATA;
          end
        end else begin
          state_next_s = ST_DATA;
        end
      end
      ST_PARITY: begin
        if (bit_end_s) state_next_s = ST_STOP;
        else           state_next_s = ST_PARITY;
      end
      ST_STOP: begin
        if (bit_end_s) begin
          bytes_next_s = bytes_r + 16'd1;
          // fifo_empty is only looked at here and in IDLE: one pop per frame
          if (enable && !fifo_empty) state_next_s = ST_POP;
          else                       state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_STOP;
        end
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // Output values for the state being entered
  always_comb begin
    tx_s = 1'b1;
    case (state_next_s)
      ST_START:  tx_s = 1'b0;
      ST_DATA:   tx_s = shift_next_s[0];
      ST_PARITY: tx_s = parity_next_s;
      default:   tx_s = 1'b1;
    endcase
    rd_en_s = (state_next_s == ST_POP);
    busy_s  = (state_next_s != ST_IDLE);
    done_s  = (state_next_s == ST_STOP) && bit_last_s;
  end

  // State, datapath and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ST_IDLE;
      shift_r   <= {WIDTH{1'b0}};
      bit_cnt_r <= {BW{1'b0}};
      parity_r  <= 1'b0;
      bytes_r   <= 16'd0;
      tx_r      <= 1'b1;
      rd_en_r   <= 1'b0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      state_r   <= state_next_s;
      shift_r   <= shift_next_s;
      bit_cnt_r <= bit_cnt_next_s;
      parity_r  <= parity_next_s;
      bytes_r   <= bytes_next_s;
      tx_r      <= tx_s;
      rd_en_r   <= rd_en_s;
      busy_r    <= busy_s;
      done_r    <= done_s;
    end
  end

  assign fifo_rd_en = rd_en_r;
  assign tx         = tx_r;
  assign busy       = busy_r;
  assign tx_done    = done_r;
  assign bytes_sent = bytes_r;

endmodule
